// File: rtl/platformniostimer_timer_sched.sv
// ---------------------------------------------------------------------------
// platformniostimer_timer_sched
//
// Shares one 32-bit interval timer among NUM_REQ requesters. In IDLE an
// arbiter picks a requester and latches its period. The block then programs
// the timer over its 16-bit slave port: period low, period high, status
// clear, and control start. It waits for the timer irq, acknowledges it, and
// pulses done to the granted requester.
//
// Optional feature macro: TIMER_SCHED_RR_EN
//   defined   -> round-robin arbitration. The search starts just after the
//                last grant.
//   undefined -> fixed priority. The lowest index wins.
//
// Ports:
//   clk, reset_n      clock; asynchronous active-low reset
//   req_valid         level request per requester, held until its done
//   req_delay         32-bit delay per requester, slot i = [32*i+31:32*i]
//   done              one-cycle completion pulse to the granted requester
//   busy              high whenever the sequencer is not idle
//   grant_id          index of the current or last granted requester
//   tmr_address       timer slave address (registered)
//   tmr_chipselect    timer slave chipselect (registered)
//   tmr_write_n       timer slave write strobe, active-low (registered)
//   tmr_writedata     timer slave write data (registered)
//   tmr_irq           timer interrupt; only honoured while waiting
// ---------------------------------------------------------------------------
module platformniostimer_timer_sched #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [32*NUM_REQ-1:0] req_delay,
  output logic [NUM_REQ-1:0]    done,
  output logic                  busy,
  output logic [IDX_W-1:0]      grant_id,
  output logic [2:0]            tmr_address,
  output logic                  tmr_chipselect,
  output logic                  tmr_write_n,
  output logic [15:0]           tmr_writedata,
  input  logic                  tmr_irq
);

  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd1;
  localparam logic [2:0] ADDR_PERIODL = 3'd2;
  localparam logic [2:0] ADDR_PERIODH = 3'd3;

  // START | ITO: one-shot run with the interrupt enabled
  localparam logic [15:0] CTRL_START = 16'h0005;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_PL,
    S_WR_PH,
    S_WR_CLR,
    S_WR_START,
    S_WAIT,
    S_WR_ACK,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     grant_q, grant_d;
  logic [31:0]          period_q, period_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 cs_q, cs_d;
  logic                 wn_q, wn_d;
  logic [2:0]           addr_q, addr_d;
  logic [15:0]          wdata_q, wdata_d;

  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;
  int                   cand;
  logic [31:0]          win_delay;
  logic [31:0]          win_period;

`ifdef TIMER_SCHED_RR_EN
  logic [IDX_W-1:0]     rr_q, rr_d;
`endif

  // Winner selection. The search walks every requester once, starting at the
  // round-robin pointer or at index 0, and takes the first one asserting.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef TIMER_SCHED_RR_EN
      cand = int'(rr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
`else
      cand = k;
`endif
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  // The timer counts P+1 cycles, so P = D-1. D of 0 or 1 clamps to P = 1,
  // because a zero period is not usable.
  assign win_delay  = req_delay[32*int'(win_idx) +: 32];
  assign win_period = (win_delay < 32'd2) ? 32'd1 : (win_delay - 32'd1);

  // Next-state logic. The bus values are derived from the next state, so the
  // registered bus outputs line up with the state that issues each write.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    period_d = period_q;
    done_d   = '0;
    cs_d     = 1'b0;
    wn_d     = 1'b1;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
`ifdef TIMER_SCHED_RR_EN
    rr_d     = rr_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d  = S_WR_PL;
          grant_d  = win_idx;
          period_d = win_period;
`ifdef TIMER_SCHED_RR_EN
          rr_d = (int'(win_idx) == NUM_REQ - 1) ? '0 : IDX_W'(int'(win_idx) + 1);
`endif
        end
      end
      S_WR_PL:    state_d = S_WR_PH;
      S_WR_PH:    state_d = S_WR_CLR;
      S_WR_CLR:   state_d = S_WR_START;
      S_WR_START: state_d = S_WAIT;
      S_WAIT:     if (tmr_irq) state_d = S_WR_ACK;
      S_WR_ACK:   state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase

    case (state_d)
      S_WR_PL: begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_PERIODL; wdata_d = period_d[15:0];
      end
      S_WR_PH: begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_PERIODH; wdata_d = period_d[31:16];
      end
      S_WR_CLR, S_WR_ACK: begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_STATUS; wdata_d = 16'h0000;
      end
      S_WR_START: begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_CONTROL; wdata_d = CTRL_START;
      end
      S_DONE:  done_d[grant_d] = 1'b1;
      default: ;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      period_q <= '0;
      done_q   <= '0;
      cs_q     <= 1'b0;
      wn_q     <= 1'b1;
      addr_q   <= '0;
      wdata_q  <= '0;
`ifdef TIMER_SCHED_RR_EN
      rr_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      period_q <= period_d;
      done_q   <= done_d;
      cs_q     <= cs_d;
      wn_q     <= wn_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
`ifdef TIMER_SCHED_RR_EN
      rr_q     <= rr_d;
`endif
    end
  end

  assign done           = done_q;
  assign busy           = (state_q != S_IDLE);
  assign grant_id       = grant_q;
  assign tmr_address    = addr_q;
  assign tmr_chipselect = cs_q;
  assign tmr_write_n    = wn_q;
  assign tmr_writedata  = wdata_q;

endmodule

// File: tb/tb_platformniostimer_timer_sched.sv
// ---------------------------------------------------------------------------
// tb_platformniostimer_timer_sched
//
// Self-checking bench for platformniostimer_timer_sched. It contains a
// behavioural model of the interval timer's s1 slave, which drives tmr_irq.
// A reference model of the scheduler predicts the following:
//   - the winner of each arbitration
//   - the four programming writes and their data
//   - the acknowledge latency
//   - the done pulse
// Stimulus mixes directed cases with random request masks and delays.
// ---------------------------------------------------------------------------
module tb_platformniostimer_timer_sched;

   localparam int NUM_REQ = 4;
   localparam int IDX_W   = 2;

   logic                  clk;
   logic                  resetN;
   logic [NUM_REQ-1:0]    reqValid;
   logic [32*NUM_REQ-1:0] reqDelay;
   logic [NUM_REQ-1:0]    done;
   logic                  busy;
   logic [IDX_W-1:0]      grantId;
   logic [2:0]            tmrAddress;
   logic                  tmrChipselect;
   logic                  tmrWriteN;
   logic [15:0]           tmrWritedata;
   logic                  tmrIrq;

   logic [31:0]           delays [NUM_REQ];
   int                    assertCount;
   int                    failCount;
   int                    rrPtr;

   // Timer model state
   logic [31:0]           tPeriod;
   logic [31:0]           tCnt;
   logic                  tTo;
   logic                  tIto;
   logic                  tRun;
   logic                  staleSet;

   platformniostimer_timer_sched #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) dut (
      .clk            (clk),
      .reset_n        (resetN),
      .req_valid      (reqValid),
      .req_delay      (reqDelay),
      .done           (done),
      .busy           (busy),
      .grant_id       (grantId),
      .tmr_address    (tmrAddress),
      .tmr_chipselect (tmrChipselect),
      .tmr_write_n    (tmrWriteN),
      .tmr_writedata  (tmrWritedata),
      .tmr_irq        (tmrIrq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) reqDelay[32*i +: 32] = delays[i];
   end

   // Interval timer model. A START write loads the counter with the period.
   // The timeout flag rises after period+1 further edges, and then the
   // one-shot run stops. Writes to the period registers force a reload and
   // stop the counter. Any write to status clears the timeout flag.
   always @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         tPeriod <= '0;
         tCnt    <= '0;
         tTo     <= 1'b0;
         tIto    <= 1'b0;
         tRun    <= 1'b0;
      end else begin
         if (tRun) begin
            if (tCnt == 0) begin
               tTo  <= 1'b1;
               tRun <= 1'b0;
               tCnt <= tPeriod;
            end else begin
               tCnt <= tCnt - 1;
            end
         end
         if (staleSet) begin
            tTo  <= 1'b1;
            tIto <= 1'b1;
         end
         if (tmrChipselect && !tmrWriteN) begin
            case (tmrAddress)
               3'd0: tTo <= 1'b0;
               3'd1: begin
                  tIto <= tmrWritedata[0];
                  if (tmrWritedata[2]) begin
                     tRun <= 1'b1;
                     tCnt <= tPeriod;
                  end
                  if (tmrWritedata[3]) tRun <= 1'b0;
               end
               3'd2: begin
                  tPeriod[15:0] <= tmrWritedata;
                  tCnt <= {tPeriod[31:16], tmrWritedata};
                  tRun <= 1'b0;
               end
               3'd3: begin
                  tPeriod[31:16] <= tmrWritedata;
                  tCnt <= {tmrWritedata, tPeriod[15:0]};
                  tRun <= 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

   assign tmrIrq = tTo & tIto;

   // Counts every comparison and reports any mismatch
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [20:0] busState();
      return {tmrChipselect, tmrWriteN, tmrAddress, tmrWritedata};
   endfunction

   // Reference arbiter: round-robin from the pointer, or the lowest index wins
   function automatic int modelPick(input logic [NUM_REQ-1:0] mask);
`ifdef TIMER_SCHED_RR_EN
      for (int k = 0; k < NUM_REQ; k++)
         if (mask[(rrPtr + k) % NUM_REQ]) return (rrPtr + k) % NUM_REQ;
`else
      for (int k = 0; k < NUM_REQ; k++)
         if (mask[k]) return k;
`endif
      return 0;
   endfunction

   // Serves one grant. Call it at a negedge with the DUT idle and requests
   // driven. dropMode selects what happens at the done pulse:
   //   0 = keep all requests
   //   1 = drop the winner's request
   //   2 = drop all requests
   task automatic applyStimulus(input int dropMode, output int w);
      logic [31:0] d;
      logic [31:0] p;
      int          deff;
      int          k;
      bit          early;
      w    = modelPick(reqValid);
      d    = delays[w];
      p    = (d < 2) ? 32'd1 : d - 32'd1;
      deff = (d < 2) ? 2 : int'(d);
      rrPtr = (w + 1) % NUM_REQ;

      @(negedge clk);
      checkOutput("wrPeriodL", busState(), {1'b1, 1'b0, 3'd2, p[15:0]});
      checkOutput("grantId", grantId, w);
      checkOutput("busyActive", busy, 1);
      @(negedge clk);
      checkOutput("wrPeriodH", busState(), {1'b1, 1'b0, 3'd3, p[31:16]});
      @(negedge clk);
      checkOutput("wrClear", busState(), {1'b1, 1'b0, 3'd0, 16'h0000});
      @(negedge clk);
      checkOutput("wrStart", busState(), {1'b1, 1'b0, 3'd1, 16'h0005});

      k = 0;
      early = 0;
      while (k < deff + 20) begin
         @(negedge clk);
         k++;
         if (done != 0) early = 1;
         if (tmrChipselect && !tmrWriteN) break;
      end
      checkOutput("noEarlyDone", early, 0);
      checkOutput("ackLatency", k, deff + 2);
      checkOutput("wrAck", busState(), {1'b1, 1'b0, 3'd0, 16'h0000});

      @(negedge clk);
      checkOutput("donePulse", done, 64'(1) << w);
      checkOutput("idleBus", {tmrChipselect, tmrWriteN}, 2'b01);
      if (dropMode == 1) reqValid[w] = 1'b0;
      else if (dropMode == 2) reqValid = '0;

      @(negedge clk);
      checkOutput("doneCleared", done, 0);
      checkOutput("idleGap", busy, 0);
   endtask

   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int w;
      int expSeq [5];
      bit sawDone;
      logic [NUM_REQ-1:0] mask;

      assertCount = 0;
      failCount   = 0;
      rrPtr       = 0;
      resetN      = 1'b0;
      reqValid    = '0;
      staleSet    = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) delays[i] = '0;

      repeat (3) @(negedge clk);
      checkOutput("resetBusy", busy, 0);
      checkOutput("resetGrant", grantId, 0);
      checkOutput("resetDone", done, 0);
      checkOutput("resetBus", busState(), {1'b0, 1'b1, 3'd0, 16'h0000});
      resetN = 1'b1;
      @(negedge clk);

      $display("[TB] single request, req 0, D=100");
      delays[0] = 32'd100;
      reqValid  = 4'b0001;
      applyStimulus(1, w);

      $display("[TB] req 2, D=0x0001_0005");
      delays[2] = 32'h0001_0005;
      reqValid  = 4'b0100;
      applyStimulus(1, w);

      $display("[TB] D=0 and D=1 clamp");
      delays[1] = 32'd0;
      reqValid  = 4'b0010;
      applyStimulus(1, w);
      delays[3] = 32'd1;
      reqValid  = 4'b1000;
      applyStimulus(1, w);

      $display("[TB] all requesters continuous, D=10");
      for (int i = 0; i < NUM_REQ; i++) delays[i] = 32'd10;
      reqValid = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         applyStimulus((i == 4) ? 2 : 0, w);
         expSeq[i] = w;
      end
`ifdef TIMER_SCHED_RR_EN
      checkOutput("rrOrder", {8'(expSeq[0]), 8'(expSeq[1]), 8'(expSeq[2]), 8'(expSeq[3]), 8'(expSeq[4])},
                  {8'd0, 8'd1, 8'd2, 8'd3, 8'd0});
`else
      checkOutput("fixedOrder", {8'(expSeq[0]), 8'(expSeq[1]), 8'(expSeq[2])}, {8'd0, 8'd0, 8'd0});
`endif

      $display("[TB] stale timeout before grant");
      staleSet = 1'b1;
      @(negedge clk);
      staleSet = 1'b0;
      delays[1] = 32'd20;
      reqValid  = 4'b0010;
      applyStimulus(1, w);

      $display("[TB] random request masks");
      for (int n = 0; n < 8; n++) begin
         mask = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
         for (int i = 0; i < NUM_REQ; i++) delays[i] = $urandom_range(0, 30);
         reqValid = mask;
         while (reqValid != 0) applyStimulus(1, w);
      end

      $display("[TB] reset during WAIT");
      delays[1] = 32'd50;
      reqValid  = 4'b0010;
      repeat (14) @(negedge clk);
      resetN = 1'b0;
      #1;
      checkOutput("midResetBusy", busy, 0);
      checkOutput("midResetGrant", grantId, 0);
      checkOutput("midResetDone", done, 0);
      checkOutput("midResetBus", busState(), {1'b0, 1'b1, 3'd0, 16'h0000});
      reqValid = '0;
      rrPtr    = 0;
      @(negedge clk);
      resetN  = 1'b1;
      sawDone = 0;
      repeat (70) begin
         @(negedge clk);
         if (done != 0 || busy) sawDone = 1;
      end
      checkOutput("noDoneAfterReset", sawDone, 0);
      delays[3] = 32'd7;
      reqValid  = 4'b1000;
      applyStimulus(1, w);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/platformniostimer_timer_sched.md
# platformniostimer_timer_sched

Sequencer and arbiter that shares the single 32-bit interval timer slave among NUM_REQ hardware requesters. Each requester posts a one-shot delay. The block arbitrates, programs the timer through its 16-bit Avalon-MM slave (period low/high, status clear, control start), waits for the timer irq, acknowledges it, and returns a done pulse to the winning requester. It sits between requester logic and the timer's s1 slave and is the timer's only master.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- IDX_W, 2: width of grant index; must equal ceil(log2(NUM_REQ)).

Ports:
- clk  in  1  clock, shared with timer.
- reset_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  level request per requester; held until its done pulse.
- req_delay  in  32*NUM_REQ  delay in clk cycles; requester i uses bits [32*i+31:32*i]; stable while req_valid[i]=1.
- done  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- busy  out  1  high in every state except IDLE.
- grant_id  out  IDX_W  index of current/last granted requester.
- tmr_address  out  3  timer slave address.
- tmr_chipselect  out  1  timer slave chipselect.
- tmr_write_n  out  1  timer slave write, active-low.
- tmr_writedata  out  16  timer slave write data.
- tmr_irq  in  1  timer interrupt (timeout flag AND ITO).

## Operation
- Timer register map used: 0 status (any write clears TO), 1 control (bit0 ITO, bit1 CONT, bit2 START, bit3 STOP), 2 period_l, 3 period_h.
- Timer slave has zero wait states, so each write occupies exactly one state/cycle. The block issues no reads.
- FSM states and transitions:
  - IDLE: if any req_valid, select winner, latch grant_id and period P, go to WR_PL.
  - WR_PL: write addr 2, data P[15:0].
  - WR_PH: write addr 3, data P[31:16]. The timer force-reloads and stops.
  - WR_CLR: write addr 0, data 0. Clears any stale timeout.
  - WR_START: write addr 1, data 16'h0005 (START|ITO, one-shot).
  - WAIT: stay until tmr_irq=1.
  - WR_ACK: write addr 0, data 0 (clears irq).
  - DONE: done[grant_id]=1, then IDLE.
- Period rule: P = D-1 for D≥2. D=0 and D=1 are clamped to P=1, i.e. effective delay 2. Computed at latch time, 32-bit unsigned, no wrap.
- Bus outputs are registered. In non-write states: chipselect=0, write_n=1, address/writedata hold last value.
- Arbitration is evaluated only in IDLE. req_valid changes during a grant do not affect the active grant. Dropping req_valid after grant does not abort.
- A requester still asserting req_valid in the cycle after DONE is re-arbitrated as a new request.
- tmr_irq seen outside WAIT is ignored; WR_CLR removes it before start.

## Timing
- Reset values: done=0, busy=0, grant_id=0, tmr_chipselect=0, tmr_write_n=1, tmr_address=0, tmr_writedata=0, FSM=IDLE, round-robin pointer=0.
- Request sampled high in IDLE at edge E0 → WR_PL write at E1, WR_PH E2, WR_CLR E3, WR_START E4.
- Timer counter=P at E4. tmr_irq rises after edge E4+D (D-cycle delay measured from the start edge).
- WAIT sees irq → WR_ACK write on the next edge → DONE the cycle after → done pulse 1 cycle.
- Total: req to done = D+7 cycles (±1 for irq sample), constant for fixed D.
- Back-to-back: next arbitration in the IDLE cycle following DONE. Minimum gap between grants is 1 IDLE cycle.
- reset_n asserted mid-operation: all outputs return to reset values asynchronously and no done pulse is issued. The timer is reset by the same net.

## Configuration
- TIMER_SCHED_RR_EN defined: round-robin arbitration. The search starts at (last grant_id+1) mod NUM_REQ, and the pointer updates on each grant.
- TIMER_SCHED_RR_EN undefined: fixed priority, lowest index wins, no pointer register.

## Test plan
- Single request, req 0, D=100 → writes (2,0x0063),(3,0),(0,0),(1,0x0005) on 4 consecutive cycles; irq 100 cycles after start edge; done[0] pulse; busy low after.
- D=0x0001_0005 on req 2 → period_l write 0x0004, period_h write 0x0001; done[2] after 65541+7 cycles.
- D=0 and D=1 → P=1 written; done after 2-cycle timer delay.
- All 4 requesting continuously, D=10 → RR_EN: grants 0,1,2,3,0; without macro: grants 0,0,0 (requester 0 re-asserts).
- Stale timeout: timer TO preset with irq high before grant → no early done; done only after the programmed delay.
- reset_n pulsed during WAIT → outputs reset immediately, no done; a fresh request after release completes normally.
